// File: rtl/uart_rx_deser.sv
// 8N1 UART receive deserializer: synchronizes the RX pad, samples mid-bit with a
// programmable clocks-per-bit divisor and hands bytes off over valid/ready.
module uart_rx_deser #(
   parameter int DIV_W  = 16,
   parameter int DATA_W = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              rx_i,
   input  logic [DIV_W-1:0]  clk_div_i,
   input  logic              rx_ready_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   output logic              frame_err_o,
   output logic              overrun_o,
   output logic              busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(4);
   localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
   localparam logic [2:0]       IDX_LAST = 3'(DATA_W - 1);

   state_t              state_q, state_d;
   logic                rx_m, rx_s;
   logic [DIV_W-1:0]    n_q, n_d;
   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          idx_q, idx_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [DATA_W-1:0]   data_d;
   logic                valid_d;
   logic                fe_d;
   logic                ov_d;
   logic [DIV_W-1:0]    n_clamp;
   logic [DIV_W-1:0]    half_m1;
   logic [DIV_W-1:0]    full_m1;

   // Two-flop synchronizer; idle-high so reset does not look like a start bit.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx_i;
         rx_s <= rx_m;
      end
   end

   assign n_clamp = (clk_div_i < DIV_MIN) ? DIV_MIN : clk_div_i;
   assign half_m1 = (n_q >> 1) - CNT_ONE;
   assign full_m1 = n_q - CNT_ONE;

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = rx_data_o;
      valid_d = rx_valid_o;
      fe_d    = 1'b0;
      ov_d    = 1'b0;

      if (rx_valid_o && rx_ready_i) begin
         valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
               n_d     = n_clamp;
            end
         end

         S_START: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == half_m1) begin
               if (!rx_s) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_DATA: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == full_m1) begin
               shift_d[idx_q] = rx_s;
               cnt_d          = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         S_STOP: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == full_m1) begin
               if (rx_s) begin
                  // Returning to IDLE mid-stop-bit lets a back-to-back start bit be caught.
                  state_d = S_IDLE;
                  if (!rx_valid_o || rx_ready_i) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ov_d = 1'b1;
                  end
               end else begin
                  fe_d    = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end

         S_BREAK: begin
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= S_IDLE;
         n_q         <= DIV_MIN;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         rx_data_o   <= '0;
         rx_valid_o  <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         rx_data_o   <= data_d;
         rx_valid_o  <= valid_d;
         frame_err_o <= fe_d;
         overrun_o   <= ov_d;
         busy_o      <= (state_d != S_IDLE);
      end
   end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Receive-side deserializer for the user-area UART.
- Sits directly upstream of the Wishbone UART register block. Takes the raw serial line from the RX pad (io_in[30]) and delivers framed bytes over a valid/ready handshake into the RX data register.
- Reports frame and overrun errors as one-cycle pulses for the status/irq logic.
- Format is fixed at 8N1, LSB first, with a programmable clocks-per-bit divisor.

Parameters:
- DIV_W, 16, width of the clocks-per-bit divisor input.
- DATA_W, 8, data bits per frame. Fixed at 8; other values are unsupported.

Ports:
- wb_clk_i  input  1  system clock; the only clock in the block.
- wb_rst_i  input  1  asynchronous, active-high reset.
- rx_i  input  1  raw serial line, asynchronous to wb_clk_i, idle high.
- clk_div_i  input  DIV_W  wb_clk_i cycles per bit. Values below 4 are treated as 4.
- rx_ready_i  input  1  consumer accepts rx_data_o this cycle.
- rx_data_o  output  8  received byte.
- rx_valid_o  output  1  rx_data_o holds an unconsumed byte.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: byte completed while the holding register was full.
- busy_o  output  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync-released usage):
  - rx_data_o=0, rx_valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
  - FSM=IDLE, both synchronizer flops=1.
- Synchronizer:
  - rx_i passes through 2 flops to give rx_s.
  - All decisions use rx_s. Pin-to-rx_s latency is 2 cycles.
- Divisor:
  - N = max(clk_div_i, 4).
  - N is sampled into an internal register on the IDLE->START transition and held for the whole frame. Changes mid-frame do not affect the current frame.
- Bit counter: cnt (DIV_W bits) and bit index idx (3 bits).
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s==0 -> START, with cnt=0.
- START:
  - cnt increments each cycle.
  - When cnt==(N>>1)-1, sample rx_s.
  - Sample 0 -> DATA, with cnt=0 and idx=0.
  - Sample 1 -> IDLE (glitch rejected, no error).
- DATA:
  - cnt increments. When cnt==N-1, sample rx_s into shift[idx] (LSB first) and set cnt=0.
  - idx==7 -> STOP, else idx+1.
- STOP:
  - When cnt==N-1, sample rx_s.
  - Sample 1: byte is good. If rx_valid_o==0 or rx_ready_i==1 this cycle, load rx_data_o=shift and set rx_valid_o=1 on the next edge. Otherwise drop the byte, pulse overrun_o, and keep the old rx_data_o. Next state IDLE.
  - Sample 0: pulse frame_err_o, drop the byte, go to BREAK.
- BREAK:
  - Stay until rx_s==1, then IDLE.
  - A held-low line yields exactly one frame_err_o pulse.
- Handshake:
  - rx_valid_o clears on the edge where rx_valid_o && rx_ready_i, unless a new byte loads on the same edge (then it stays 1 with the new data).
  - rx_data_o is stable while rx_valid_o=1 and not yet accepted.
  - rx_ready_i is ignored when rx_valid_o=0.
- Sampling point: mid-bit. The start bit is sampled at (N>>1) cycles after rx_s falls, and each later bit N cycles after the previous sample.
- Latency: the last edge of rx_s stop-bit sampling to rx_valid_o=1 is 1 cycle. From rx_i start edge to rx_valid_o, nominal latency is 2 + (N>>1) + 9N + 1 cycles.
- Back-to-back frames: IDLE is reached mid-stop-bit, so a start bit immediately following the stop bit is detected correctly.
- Simultaneous events: frame_err_o and overrun_o are mutually exclusive, because overrun is only evaluated on a good stop bit.
- busy_o = (state != IDLE). It is registered along with the state.
- Reset mid-frame: immediate return to the reset state. The partial byte is discarded and no pulse is generated.

Test Plan:
- clk_div_i=8, send 0xA5 8N1, rx_ready_i=1 -> rx_valid_o high exactly 1 cycle, rx_data_o=0xA5, valid at 2+4+72+1=79 cycles after the start edge ±1, no error pulses.
- clk_div_i=16, send 0x3C then 0xC3 back-to-back with rx_ready_i=0 -> first byte 0x3C held with rx_valid_o=1, overrun_o pulses once at the second stop sample, rx_data_o stays 0x3C; then raise rx_ready_i -> rx_valid_o falls next edge.
- clk_div_i=8, frame 0x55 with stop bit driven 0, line then held low for 40 cycles -> one frame_err_o pulse, rx_valid_o stays 0, busy_o=1 until the line returns high, then IDLE.
- clk_div_i=8, 2-cycle low glitch on rx_i -> FSM returns to IDLE after the START sample, no valid, no errors.
- clk_div_i=2 (clamped to 4), send 0x81 -> rx_data_o=0x81; assert wb_rst_i during the DATA bits of a second frame -> all outputs 0 immediately, then the next clean frame 0x7E is received correctly.
- clk_div_i=10, rx_ready_i held 1, send 0x00 and 0xFF consecutively -> two single-cycle rx_valid_o pulses carrying 0x00 and 0xFF.
